// File: rtl/c3lib_gf_clksel_ctrl_if.sv
// Register-side clock-select request and status bundle for the glitch-free mux sequencer.
// The master drives the requests and observes status; the slave is the sequencer itself.
interface c3lib_gf_clksel_ctrl_if #(
   parameter int SETTLE_W = 8,
   parameter int CNT_W    = 8
);
   logic                i_sel_req;
   logic [SETTLE_W-1:0] i_settle_cnt;
   logic                i_cnt_clr;
   logic                o_sel_clk;
   logic                o_busy;
   logic                o_sw_done;
   logic                o_cur_sel;
   logic [CNT_W-1:0]    o_sw_cnt;

   modport master (
      output i_sel_req, i_settle_cnt, i_cnt_clr,
      input  o_sel_clk, o_busy, o_sw_done, o_cur_sel, o_sw_cnt
   );

   modport slave (
      input  i_sel_req, i_settle_cnt, i_cnt_clr,
      output o_sel_clk, o_busy, o_sw_done, o_cur_sel, o_sw_cnt
   );
endinterface

// File: rtl/c3lib_gf_clksel_ctrl.sv
// Sequences o_sel_clk for the glitch-free mux: holds it for a settle window, then confirms.
// Select updates one cycle after a mismatch in IDLE; all outputs registered; no backpressure.
module c3lib_gf_clksel_ctrl #(
   parameter int SETTLE_W  = 8,
   parameter bit RESET_SEL = 1'b0,
   parameter int CNT_W     = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_scan_mode_n,
   c3lib_gf_clksel_ctrl_if.slave   bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0]    CNT_MAX    = '1;
   localparam logic [SETTLE_W-1:0] SETTLE_ONE = SETTLE_W'(1);

   state_t              state_q, state_d;
   logic                sel_clk_q, sel_clk_d;
   logic                cur_sel_q, cur_sel_d;
   logic                busy_q, busy_d;
   logic                sw_done_q, sw_done_d;
   logic [SETTLE_W-1:0] settle_q, settle_d;
   logic [CNT_W-1:0]    sw_cnt_q, sw_cnt_d;

   logic                req_diff;
   logic                settle_last;

   assign req_diff    = (bus.i_sel_req != sel_clk_q);
   assign settle_last = (settle_q == SETTLE_ONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (!i_scan_mode_n) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: if (req_diff) state_d = ST_WAIT;
            ST_WAIT: if (settle_last) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Scan freezes the select/confirm/counter state and only drops busy/done.
   always_comb begin
      sel_clk_d = sel_clk_q;
      cur_sel_d = cur_sel_q;
      settle_d  = settle_q;
      sw_cnt_d  = sw_cnt_q;
      busy_d    = 1'b0;
      sw_done_d = 1'b0;
      if (i_scan_mode_n) begin
         case (state_q)
            ST_IDLE: begin
               if (req_diff) begin
                  sel_clk_d = bus.i_sel_req;
                  settle_d  = (bus.i_settle_cnt == '0) ? SETTLE_ONE : bus.i_settle_cnt;
                  busy_d    = 1'b1;
               end
            end
            ST_WAIT: begin
               if (settle_last) begin
                  settle_d  = '0;
                  sw_done_d = 1'b1;
                  cur_sel_d = sel_clk_q;
                  if (sw_cnt_q != CNT_MAX) begin
                     sw_cnt_d = sw_cnt_q + CNT_W'(1);
                  end
               end else begin
                  settle_d = settle_q - SETTLE_ONE;
                  busy_d   = 1'b1;
               end
            end
            default: begin
            end
         endcase
         if (bus.i_cnt_clr) begin
            sw_cnt_d = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_clk_q <= RESET_SEL;
         cur_sel_q <= RESET_SEL;
         busy_q    <= 1'b0;
         sw_done_q <= 1'b0;
         settle_q  <= '0;
         sw_cnt_q  <= '0;
      end else begin
         sel_clk_q <= sel_clk_d;
         cur_sel_q <= cur_sel_d;
         busy_q    <= busy_d;
         sw_done_q <= sw_done_d;
         settle_q  <= settle_d;
         sw_cnt_q  <= sw_cnt_d;
      end
   end

   assign bus.o_sel_clk = sel_clk_q;
   assign bus.o_cur_sel = cur_sel_q;
   assign bus.o_busy    = busy_q;
   assign bus.o_sw_done = sw_done_q;
   assign bus.o_sw_cnt  = sw_cnt_q;

endmodule
